// File: rtl/shot_dispatcher_if.sv
// Player-control / bullet-engine bundle for the shot dispatcher.
// The slave side is the dispatcher; the master side is its environment
// (input controller plus bullet engine).
interface shot_dispatcher_if #(
   parameter int CNT_W = 3
);
   logic             frame_tick;
   logic             fire;
   logic [1:0]       fire_mode;
   logic [3:0]       ss_angle_state;
   logic             spawn_ready;
   logic             shot_done;
   logic             spawn_valid;
   logic [3:0]       spawn_angle;
   logic [1:0]       spawn_mode;
   logic [CNT_W-1:0] in_flight;
   logic             busy;

   modport master (
      output frame_tick, fire, fire_mode, ss_angle_state, spawn_ready, shot_done,
      input  spawn_valid, spawn_angle, spawn_mode, in_flight, busy
   );

   modport slave (
      input  frame_tick, fire, fire_mode, ss_angle_state, spawn_ready, shot_done,
      output spawn_valid, spawn_angle, spawn_mode, in_flight, busy
   );
endinterface

// File: rtl/shot_dispatcher.sv
// Shot dispatcher: turns fire presses into bullet spawn requests using
// single / burst / spread patterns, a frame-based cooldown and an
// in-flight bullet cap.
module shot_dispatcher #(
   parameter int MAX_SHOTS        = 4,
   parameter int CNT_W            = 3,
   parameter int BURST_LEN        = 3,
   parameter int BURST_GAP_FRAMES = 4,
   parameter int COOLDOWN_FRAMES  = 8
) (
   input logic              clk,
   input logic              rst_n,
   shot_dispatcher_if.slave bus
);

   // Frame counter only needs to reach the larger of the two waits minus one.
   localparam int FMAX     = (BURST_GAP_FRAMES > COOLDOWN_FRAMES) ? BURST_GAP_FRAMES : COOLDOWN_FRAMES;
   localparam int FCNT_W   = (FMAX < 2) ? 1 : $clog2(FMAX);
   // Shot index must cover a whole burst and the three spread shots.
   localparam int SHOT_MAX = (BURST_LEN > 3) ? BURST_LEN : 3;
   localparam int SHOT_W   = $clog2(SHOT_MAX);

   localparam logic [FCNT_W-1:0] GAP_LAST   = FCNT_W'(BURST_GAP_FRAMES - 1);
   localparam logic [FCNT_W-1:0] CD_LAST    = FCNT_W'((COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1);
   localparam logic [SHOT_W-1:0] BURST_LAST = SHOT_W'(BURST_LEN - 1);
   localparam logic [SHOT_W-1:0] SPREAD_LAST = SHOT_W'(2);
   localparam logic [CNT_W-1:0]  CAP        = CNT_W'(MAX_SHOTS);

   localparam logic [1:0] MODE_SINGLE = 2'd0;
   localparam logic [1:0] MODE_BURST  = 2'd1;
   localparam logic [1:0] MODE_SPREAD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_GAP      = 2'd2,
      ST_COOLDOWN = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic               r_fire_prev;
   logic [3:0]         r_angle;
   logic [3:0]         w_angle_next;
   logic [1:0]         r_mode;
   logic [1:0]         w_mode_next;
   logic [SHOT_W-1:0]  r_shot_cnt;
   logic [SHOT_W-1:0]  w_shot_next;
   logic [FCNT_W-1:0]  r_frame_cnt;
   logic [FCNT_W-1:0]  w_frame_next;
   logic [CNT_W-1:0]   r_in_flight;

   logic               w_trigger;
   logic               w_full;
   logic               w_valid;
   logic               w_accept;
   logic [1:0]         w_mode_sel;

   assign w_trigger  = bus.fire & ~r_fire_prev;
   assign w_full     = (r_in_flight == CAP);
   // Valid depends on fullness so a full engine never sees a request;
   // while presenting, only our own accept can raise in_flight.
   assign w_valid    = (r_state == ST_ISSUE) && !w_full;
   assign w_accept   = w_valid & bus.spawn_ready;
   assign w_mode_sel = (bus.fire_mode == 2'd3) ? MODE_SPREAD : bus.fire_mode;

   assign bus.spawn_valid = w_valid;
   assign bus.spawn_angle = r_angle;
   assign bus.spawn_mode  = r_mode;
   assign bus.in_flight   = r_in_flight;
   assign bus.busy        = (r_state != ST_IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and volley bookkeeping (angle, mode, shot index, frame count).
   always_comb begin
      w_state_next = r_state;
      w_angle_next = r_angle;
      w_mode_next  = r_mode;
      w_shot_next  = r_shot_cnt;
      w_frame_next = r_frame_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_trigger && !w_full) begin
               w_mode_next  = w_mode_sel;
               w_shot_next  = '0;
               w_state_next = ST_ISSUE;
               // Spread starts one step counter-clockwise of the base angle.
               w_angle_next = (w_mode_sel == MODE_SPREAD) ? (bus.ss_angle_state - 4'd1)
                                                          : bus.ss_angle_state;
            end
         end
         ST_ISSUE: begin
            if (w_full) begin
               // No room: drop the rest of the volley.
               w_state_next = ST_COOLDOWN;
               w_frame_next = '0;
            end else if (w_accept) begin
               case (r_mode)
                  MODE_SINGLE: begin
                     w_state_next = ST_COOLDOWN;
                     w_frame_next = '0;
                  end
                  MODE_BURST: begin
                     w_frame_next = '0;
                     if (r_shot_cnt == BURST_LAST) begin
                        w_state_next = ST_COOLDOWN;
                     end else begin
                        w_state_next = ST_GAP;
                        w_shot_next  = r_shot_cnt + 1'b1;
                     end
                  end
                  default: begin
                     if (r_shot_cnt == SPREAD_LAST) begin
                        w_state_next = ST_COOLDOWN;
                        w_frame_next = '0;
                     end else begin
                        w_shot_next  = r_shot_cnt + 1'b1;
                        w_angle_next = r_angle + 4'd1;
                     end
                  end
               endcase
            end
         end
         ST_GAP: begin
            if (bus.frame_tick) begin
               if (r_frame_cnt == GAP_LAST) begin
                  // Re-sample the ship angle so the player can steer the burst.
                  w_state_next = ST_ISSUE;
                  w_angle_next = bus.ss_angle_state;
               end else begin
                  w_frame_next = r_frame_cnt + 1'b1;
               end
            end
         end
         ST_COOLDOWN: begin
            if (COOLDOWN_FRAMES == 0) begin
               w_state_next = ST_IDLE;
            end else if (bus.frame_tick) begin
               if (r_frame_cnt == CD_LAST) begin
                  w_state_next = ST_IDLE;
               end else begin
                  w_frame_next = r_frame_cnt + 1'b1;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Volley datapath registers and the fire edge detector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fire_prev <= 1'b0;
         r_angle     <= '0;
         r_mode      <= '0;
         r_shot_cnt  <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_fire_prev <= bus.fire;
         r_angle     <= w_angle_next;
         r_mode      <= w_mode_next;
         r_shot_cnt  <= w_shot_next;
         r_frame_cnt <= w_frame_next;
      end
   end

   // Bullets in flight: +1 per accept, -1 per retirement, floor at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_flight <= '0;
      end else if (w_accept && !bus.shot_done) begin
         r_in_flight <= r_in_flight + 1'b1;
      end else if (!w_accept && bus.shot_done && (r_in_flight != '0)) begin
         r_in_flight <= r_in_flight - 1'b1;
      end
   end

endmodule

// File: tb/tb_shot_dispatcher.sv
// Directed bench for shot_dispatcher with a spawn scoreboard.
module tb_shot_dispatcher;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   logic [5:0] sb_q[$];   // {mode, angle} of each expected spawn, in order

   shot_dispatcher_if #(.CNT_W(3)) bus ();

   shot_dispatcher #(
      .MAX_SHOTS(4), .CNT_W(3), .BURST_LEN(3),
      .BURST_GAP_FRAMES(4), .COOLDOWN_FRAMES(8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance n clocks; inputs change 1 time unit after the edge.
   task automatic clk_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // n frames: two quiet cycles then a one-cycle frame_tick.
   task automatic frames(input int n);
      repeat (n) begin
         clk_n(2);
         bus.frame_tick = 1'b1;
         clk_n(1);
         bus.frame_tick = 1'b0;
      end
   endtask

   task automatic retire(input int n);
      bus.shot_done = 1'b1;
      clk_n(n);
      bus.shot_done = 1'b0;
   endtask

   // Scoreboard: every accepted spawn must match the next expected entry.
   always @(negedge clk) begin
      logic [5:0] e;
      if (bus.spawn_valid === 1'b1 && bus.spawn_ready === 1'b1) begin
         check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_angle", 32'(bus.spawn_angle), 32'(e[3:0]));
            check("sb_mode", 32'(bus.spawn_mode), 32'(e[5:4]));
            $display("spawn accepted angle=%0d mode=%0d in_flight=%0d",
                     bus.spawn_angle, bus.spawn_mode, bus.in_flight);
         end
      end
   end

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      bus.frame_tick = 1'b0;
      bus.fire = 1'b0;
      bus.fire_mode = 2'd0;
      bus.ss_angle_state = 4'd0;
      bus.spawn_ready = 1'b0;
      bus.shot_done = 1'b0;

      // Reset state
      clk_n(3);
      @(negedge clk);
      check("rst_valid", 32'(bus.spawn_valid), 32'd0);
      check("rst_angle", 32'(bus.spawn_angle), 32'd0);
      check("rst_mode", 32'(bus.spawn_mode), 32'd0);
      check("rst_inflight", 32'(bus.in_flight), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      clk_n(1);
      rst_n = 1'b1;
      clk_n(2);

      // Single shot at angle 5
      bus.fire_mode = 2'd0; bus.ss_angle_state = 4'd5; bus.spawn_ready = 1'b1; bus.fire = 1'b1;
      sb_q.push_back({2'd0, 4'd5});
      @(negedge clk);
      check("single_valid_trigcyc", 32'(bus.spawn_valid), 32'd0);
      clk_n(1);
      bus.fire = 1'b0;
      @(negedge clk);
      check("single_valid", 32'(bus.spawn_valid), 32'd1);
      check("single_busy", 32'(bus.busy), 32'd1);
      clk_n(1);
      @(negedge clk);
      check("single_inflight", 32'(bus.in_flight), 32'd1);
      check("single_valid_done", 32'(bus.spawn_valid), 32'd0);
      frames(7);
      @(negedge clk);
      check("single_busy_7f", 32'(bus.busy), 32'd1);
      frames(1);
      @(negedge clk);
      check("single_busy_8f", 32'(bus.busy), 32'd0);
      retire(1);
      @(negedge clk);
      check("retire_to0", 32'(bus.in_flight), 32'd0);

      // Spread with wrap: angles 15, 0, 1 back to back
      bus.fire_mode = 2'd3; bus.ss_angle_state = 4'd0; bus.fire = 1'b1;
      sb_q.push_back({2'd2, 4'd15});
      sb_q.push_back({2'd2, 4'd0});
      sb_q.push_back({2'd2, 4'd1});
      clk_n(1);
      bus.fire = 1'b0;
      clk_n(3);
      @(negedge clk);
      check("spread_inflight", 32'(bus.in_flight), 32'd3);
      check("spread_valid_end", 32'(bus.spawn_valid), 32'd0);
      frames(8);

      // Capacity: in_flight=3, spread -> only one shot
      bus.fire_mode = 2'd2; bus.ss_angle_state = 4'd8; bus.fire = 1'b1;
      sb_q.push_back({2'd2, 4'd7});
      clk_n(1);
      bus.fire = 1'b0;
      clk_n(1);
      @(negedge clk);
      check("cap_inflight", 32'(bus.in_flight), 32'd4);
      check("cap_valid_full", 32'(bus.spawn_valid), 32'd0);
      clk_n(1);
      @(negedge clk);
      check("cap_cooldown_busy", 32'(bus.busy), 32'd1);
      frames(8);
      @(negedge clk);
      check("cap_idle", 32'(bus.busy), 32'd0);
      bus.fire = 1'b1;
      clk_n(1);
      bus.fire = 1'b0;
      @(negedge clk);
      check("full_trig_busy", 32'(bus.busy), 32'd0);
      clk_n(2);
      @(negedge clk);
      check("full_trig_valid", 32'(bus.spawn_valid), 32'd0);

      // Drain, then underflow guard
      retire(4);
      @(negedge clk);
      check("drain_inflight", 32'(bus.in_flight), 32'd0);
      retire(2);
      @(negedge clk);
      check("underflow_inflight", 32'(bus.in_flight), 32'd0);

      // Single, then press during cooldown and keep fire held high
      bus.fire_mode = 2'd0; bus.ss_angle_state = 4'd9; bus.fire = 1'b1;
      sb_q.push_back({2'd0, 4'd9});
      clk_n(1);
      bus.fire = 1'b0;
      clk_n(1);
      bus.fire = 1'b1;
      clk_n(2);
      @(negedge clk);
      check("cd_trig_valid", 32'(bus.spawn_valid), 32'd0);
      frames(8);
      clk_n(3);
      @(negedge clk);
      check("held_busy", 32'(bus.busy), 32'd0);
      check("held_valid", 32'(bus.spawn_valid), 32'd0);
      bus.fire = 1'b0;
      clk_n(1);

      // Accept and shot_done together -> in_flight unchanged
      bus.ss_angle_state = 4'd10; bus.fire = 1'b1;
      sb_q.push_back({2'd0, 4'd10});
      clk_n(1);
      bus.fire = 1'b0;
      retire(1);
      @(negedge clk);
      check("acc_done_inflight", 32'(bus.in_flight), 32'd1);
      frames(8);

      // Burst with back-pressure and steering
      bus.spawn_ready = 1'b0; bus.fire_mode = 2'd1; bus.ss_angle_state = 4'd2; bus.fire = 1'b1;
      sb_q.push_back({2'd1, 4'd2});
      clk_n(1);
      bus.fire = 1'b0;
      bus.ss_angle_state = 4'd7;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(bus.spawn_valid), 32'd1);
         check("bp_angle", 32'(bus.spawn_angle), 32'd2);
         clk_n(1);
      end
      bus.spawn_ready = 1'b1;
      clk_n(1);
      @(negedge clk);
      check("burst1_inflight", 32'(bus.in_flight), 32'd2);
      check("burst_gap_valid", 32'(bus.spawn_valid), 32'd0);
      bus.ss_angle_state = 4'd4;
      sb_q.push_back({2'd1, 4'd4});
      frames(3);
      @(negedge clk);
      check("gap_3f_valid", 32'(bus.spawn_valid), 32'd0);
      frames(1);
      @(negedge clk);
      check("gap_4f_valid", 32'(bus.spawn_valid), 32'd1);
      check("gap_4f_angle", 32'(bus.spawn_angle), 32'd4);
      clk_n(1);
      bus.ss_angle_state = 4'd6;
      sb_q.push_back({2'd1, 4'd6});
      frames(3);
      @(negedge clk);
      check("gap2_3f_valid", 32'(bus.spawn_valid), 32'd0);
      frames(1);
      @(negedge clk);
      check("gap2_4f_valid", 32'(bus.spawn_valid), 32'd1);
      clk_n(1);
      @(negedge clk);
      check("burst_inflight", 32'(bus.in_flight), 32'd4);
      frames(8);
      retire(4);

      // Asynchronous reset mid-burst
      bus.fire_mode = 2'd1; bus.ss_angle_state = 4'd3; bus.fire = 1'b1;
      sb_q.push_back({2'd1, 4'd3});
      clk_n(1);
      bus.fire = 1'b0;
      clk_n(1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.spawn_valid), 32'd0);
      check("arst_inflight", 32'(bus.in_flight), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_angle", 32'(bus.spawn_angle), 32'd0);
      check("arst_mode", 32'(bus.spawn_mode), 32'd0);
      #3 rst_n = 1'b1;
      clk_n(3);
      frames(5);
      @(negedge clk);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      bus.fire_mode = 2'd0; bus.ss_angle_state = 4'd11; bus.fire = 1'b1;
      sb_q.push_back({2'd0, 4'd11});
      clk_n(1);
      bus.fire = 1'b0;
      clk_n(1);
      @(negedge clk);
      check("post_rst_inflight", 32'(bus.in_flight), 32'd1);
      clk_n(2);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/shot_dispatcher.md
Name: shot_dispatcher

Overview:
- Consumer end of the player-control interface: takes the spaceship angle state, fire level and fire mode and turns fire presses into spawn requests for the bullet engine.
- Applies per-mode firing patterns (single, burst, spread), a frame-based cooldown and a cap on bullets in flight.
- Sits between the player input controller and the bullet/projectile engine.

Parameters:
- MAX_SHOTS, 4, maximum bullets in flight (1..7).
- CNT_W, 3, width of the in-flight counter (must hold MAX_SHOTS).
- BURST_LEN, 3, shots per burst (mode 1).
- BURST_GAP_FRAMES, 4, frame_ticks between burst shots (must be at least 1).
- COOLDOWN_FRAMES, 8, frame_ticks after the last shot of a volley before the next trigger is accepted (0 allowed).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- fire  in  1  synchronous fire level from the input controller.
- fire_mode  in  2  0=single, 1=burst, 2=spread, 3 treated as 2.
- ss_angle_state  in  4  current spaceship angle, 16 positions, wraps.
- spawn_ready  in  1  bullet engine accepts the spawn this cycle.
- shot_done  in  1  one-cycle pulse when a bullet leaves the screen or hits.
- spawn_valid  out  1  spawn request pending.
- spawn_angle  out  4  angle of the requested bullet.
- spawn_mode  out  2  mode of the volley that produced it (0..2).
- in_flight  out  CNT_W  bullets currently in flight.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; spawn_valid=0, spawn_angle=0, spawn_mode=0, in_flight=0, busy=0; the fire edge register is cleared. All counters are cleared.
- Trigger definition: fire=1 and fire_prev=0, where fire_prev is a register.
  - A trigger is only honoured in IDLE. Triggers in any other state are discarded, not queued.
  - A trigger in IDLE with in_flight==MAX_SHOTS is ignored and the block stays in IDLE.
- On trigger:
  - Latch mode, mapping 3 to 2.
  - Latch the base angle A from ss_angle_state.
  - Go to ISSUE.
  - spawn_valid rises the cycle after the trigger cycle.
- ISSUE: spawn_valid=1; spawn_angle and spawn_mode stay stable while spawn_valid=1 and spawn_ready=0.
  - An accept (valid and ready in the same cycle) increments in_flight.
- Mode 0 (single): one shot at A. On accept, go to COOLDOWN.
- Mode 1 (burst): BURST_LEN shots.
  - Each shot's angle is the ss_angle_state value sampled on entry to ISSUE, so the player can steer the burst.
  - After each non-final accept, go to GAP.
  - GAP waits BURST_GAP_FRAMES frame_ticks, then returns to ISSUE.
  - After the final accept, go to COOLDOWN.
- Mode 2 (spread): three shots issued back-to-back at angles A-1, A, A+1, each modulo 16 (A=0 gives 15, 0, 1).
  - The next shot is presented the cycle after the previous accept.
- Capacity: if in_flight==MAX_SHOTS when a shot is about to be presented, the remaining shots of the volley are dropped and the block goes to COOLDOWN. spawn_valid is never raised when full.
- COOLDOWN: returns to IDLE after COOLDOWN_FRAMES frame_ticks.
  - With COOLDOWN_FRAMES=0, it returns to IDLE on the next cycle.
- Frame counting in GAP and COOLDOWN: a frame_tick in the entry cycle is not counted. The state is exited on the cycle after the Nth counted tick.
- in_flight update:
  - Accept only: +1.
  - shot_done only: -1.
  - Both in the same cycle: unchanged.
  - shot_done with in_flight=0: ignored, no underflow.
- A trigger held high for many cycles counts as a single trigger. A new press requires fire to return to 0.
- Reset mid-volley aborts the volley immediately. Remaining shots are lost and in_flight is cleared.

Test Plan:
- Single shot: reset, fire_mode=0, angle=5, pulse fire, spawn_ready=1 -> one spawn (angle 5, mode 0) one cycle after the edge, in_flight=1, busy clears after 8 frame_ticks.
- Spread wrap: fire_mode=3, angle=0, spawn_ready=1 -> three consecutive spawns with angles 15, 0, 1 and spawn_mode=2; in_flight=3.
- Burst steering with back-pressure:
  - fire_mode=1, angle=2; hold spawn_ready=0 for 5 cycles -> spawn_valid held and angle stable at 2.
  - Then ready -> accept.
  - Change angle to 4 during GAP -> second shot at angle 4, exactly 4 frame_ticks later.
  - Third shot follows after another 4 frame_ticks.
- Capacity: MAX_SHOTS=4, in_flight=3, spread trigger -> only the first shot is issued, in_flight=4, then COOLDOWN. A further trigger in IDLE while full -> ignored.
- Counter edges: shot_done and accept in the same cycle -> in_flight unchanged. shot_done at 0 -> stays 0. Trigger during COOLDOWN or with fire held high -> no spawn.
- Async reset: assert rst_n=0 mid-burst between clock edges -> all outputs reach reset values immediately; after release, no spawns until a new fire edge.
